// File: rtl/rr_mux_reg_if.sv
// Handshake bundle between requesters, the arbitrating register stage and its consumer.
// The master side drives requests and downstream ready; the slave side is the mux itself.
interface rr_mux_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SRC_W      = 2
);
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]             out_src;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered N-to-1 mux with built-in round-robin or fixed-priority arbitration and a
// one-entry output register that sustains one beat per cycle under continuous demand.
module rr_mux_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int MODE       = 0,
  parameter int SRC_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_mux_reg_if.slave bus
);

  if (NUM_IN < 1) begin : g_bad_num_in
    $error("rr_mux_reg: NUM_IN must be at least 1");
  end
  if (SRC_W != ((NUM_IN > 1) ? $clog2(NUM_IN) : 1)) begin : g_bad_src_w
    $error("rr_mux_reg: SRC_W must equal max(1, clog2(NUM_IN))");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]      out_src_q;
  logic [SRC_W-1:0]      rr_ptr_q;

  logic                  free_s;
  logic                  grant_any_s;
  logic [SRC_W-1:0]      grant_idx_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_IN-1:0]     in_ready_s;
  logic [SRC_W-1:0]      rr_ptr_d;
  int                    dist_s;
  int                    best_dist_s;

  assign free_s = (state_q == EMPTY) || bus.out_ready;

  // Pick the requester nearest to rr_ptr going upward with wrap; in fixed-priority
  // mode the pointer is pinned at 0 so this degenerates to lowest index wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    best_dist_s = NUM_IN;
    dist_s      = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      dist_s = i - int'(rr_ptr_q);
      if (dist_s < 0) begin
        dist_s = dist_s + NUM_IN;
      end else begin
        dist_s = dist_s;
      end
      if (bus.in_valid[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        grant_any_s = 1'b1;
        grant_idx_s = SRC_W'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Reset gating keeps in_ready low while rst_n is asserted, independent of the flops.
  assign xfer_s = rst_n && free_s && grant_any_s;

  // One-hot accept and data selection for the granted channel.
  always_comb begin
    in_ready_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx_s == SRC_W'(i)) begin
        in_ready_s[i] = xfer_s;
        sel_data_s    = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  // Pointer advances past the winner so it has lowest priority next time.
  always_comb begin
    if (MODE != 0) begin
      rr_ptr_d = '0;
    end else if (int'(grant_idx_s) == (NUM_IN - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx_s + SRC_W'(1);
    end
  end

  // Output register FSM: EMPTY captures, FULL holds until drained or replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_s) begin
            state_q    <= FULL;
            out_data_q <= sel_data_s;
            out_src_q  <= grant_idx_s;
            rr_ptr_q   <= rr_ptr_d;
          end else begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (xfer_s) begin
            state_q    <= FULL;
            out_data_q <= sel_data_s;
            out_src_q  <= grant_idx_s;
            rr_ptr_q   <= rr_ptr_d;
          end else if (bus.out_ready) begin
            state_q <= EMPTY;
          end else begin
            state_q <= FULL;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux_reg.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and compares
// both against a per-cycle reference model of the arbitration and output register rules.
module tb_rr_mux_reg;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n_s = 1'b0;
  logic [N*DW-1:0] in_data_s = '0;
  logic [N-1:0]   in_valid_s = '0;
  logic           out_ready_s = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];
  int            m_src   [2];
  int            m_ptr   [2];
  int            m_grant [2];

  always #5 clk = ~clk;

  rr_mux_reg_if #(.DATA_WIDTH(DW), .NUM_IN(N), .SRC_W(SW)) if0 ();
  rr_mux_reg_if #(.DATA_WIDTH(DW), .NUM_IN(N), .SRC_W(SW)) if1 ();

  assign if0.in_data   = in_data_s;
  assign if0.in_valid  = in_valid_s;
  assign if0.out_ready = out_ready_s;
  assign if1.in_data   = in_data_s;
  assign if1.in_valid  = in_valid_s;
  assign if1.out_ready = out_ready_s;

  rr_mux_reg #(.DATA_WIDTH(DW), .NUM_IN(N), .MODE(0), .SRC_W(SW)) u_rr (
    .clk(clk), .rst_n(rst_n_s), .bus(if0.slave));
  rr_mux_reg #(.DATA_WIDTH(DW), .NUM_IN(N), .MODE(1), .SRC_W(SW)) u_fp (
    .clk(clk), .rst_n(rst_n_s), .bus(if1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = '0;
      m_src[m]   = 0;
      m_ptr[m]   = 0;
      m_grant[m] = -1;
    end
  endtask

  // Search starting at the pointer, wrapping; fixed priority keeps pointer at 0.
  function automatic int model_grant(input int m);
    if (!rst_n_s) return -1;
    if (m_valid[m] && !out_ready_s) return -1;
    for (int k = 0; k < N; k++) begin
      if (in_valid_s[(m_ptr[m] + k) % N]) return (m_ptr[m] + k) % N;
    end
    return -1;
  endfunction

  task automatic check_one(input int m, input logic [N-1:0] rdy, input logic ov,
                           input logic [DW-1:0] od, input logic [SW-1:0] os);
    logic [N-1:0] exp_rdy;
    m_grant[m] = model_grant(m);
    exp_rdy = '0;
    if (m_grant[m] >= 0) exp_rdy[m_grant[m]] = 1'b1;
    chk($sformatf("dut%0d in_ready", m), 64'(rdy), 64'(exp_rdy));
    chk($sformatf("dut%0d out_valid", m), 64'(ov), 64'(m_valid[m]));
    chk($sformatf("dut%0d out_data", m), 64'(od), 64'(m_data[m]));
    chk($sformatf("dut%0d out_src", m), 64'(os), 64'(m_src[m]));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_one(0, if0.in_ready, if0.out_valid, if0.out_data, if0.out_src);
    check_one(1, if1.in_ready, if1.out_valid, if1.out_data, if1.out_src);
    @(posedge clk);
    if (rst_n_s) begin
      for (int m = 0; m < 2; m++) begin
        if (m_grant[m] >= 0) begin
          m_valid[m] = 1'b1;
          m_data[m]  = in_data_s[m_grant[m]*DW +: DW];
          m_src[m]   = m_grant[m];
          if (m == 0) m_ptr[m] = (m_grant[m] + 1) % N;
        end else if (m_valid[m] && out_ready_s) begin
          m_valid[m] = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) in_data_s[i*DW +: DW] = 32'hA0 + 32'(i);

    // Held in reset, then idle after release.
    cycle();
    rst_n_s = 1'b1;
    out_ready_s = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("idle in_ready", 64'(if0.in_ready), 64'h0);

    // Round-robin sweep across all four requesters.
    in_valid_s = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_seq src", 64'(if0.out_src), 64'(k % 4));
      chk("rr_seq data", 64'(if0.out_data), 64'(32'hA0 + 32'(k % 4)));
      chk("rr_seq valid", 64'(if0.out_valid), 64'h1);
    end

    // Move pointer to 2, then alternate between channels 3 and 1.
    in_valid_s = 4'b0010;
    cycle();
    in_valid_s = 4'b1010;
    cycle(); chk("alt src a", 64'(if0.out_src), 64'd3);
    cycle(); chk("alt src b", 64'(if0.out_src), 64'd1);
    cycle(); chk("alt src c", 64'(if0.out_src), 64'd3);

    // Backpressure while holding a beat from channel 2.
    in_valid_s = 4'b0100;
    in_data_s[2*DW +: DW] = 32'hDEADBEEF;
    cycle();
    out_ready_s = 1'b0;
    in_valid_s = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp data", 64'(if0.out_data), 64'hDEADBEEF);
      chk("bp src", 64'(if0.out_src), 64'd2);
      chk("bp valid", 64'(if0.out_valid), 64'h1);
      chk("bp in_ready", 64'(if0.in_ready), 64'h0);
    end
    out_ready_s = 1'b1;
    #1 chk("bp release grant", 64'(if0.in_ready), 64'b1000);
    cycle();
    chk("bp release src", 64'(if0.out_src), 64'd3);

    // Fixed priority: channel 0 always wins until it drops.
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fp src0", 64'(if1.out_src), 64'd0);
    end
    in_valid_s = 4'b1110;
    cycle();
    chk("fp src1", 64'(if1.out_src), 64'd1);

    // Asynchronous reset while holding a beat with pointer at 3.
    in_valid_s = 4'b0100;
    cycle();
    in_valid_s = 4'b0000;
    out_ready_s = 1'b0;
    #2 rst_n_s = 1'b0;
    #1;
    chk("async rst valid0", 64'(if0.out_valid), 64'h0);
    chk("async rst valid1", 64'(if1.out_valid), 64'h0);
    chk("async rst data0", 64'(if0.out_data), 64'h0);
    model_reset();
    in_valid_s = 4'b1111;
    cycle();
    rst_n_s = 1'b1;
    out_ready_s = 1'b1;
    #1 chk("post rst grant", 64'(if0.in_ready), 64'b0001);
    cycle();
    chk("post rst src", 64'(if0.out_src), 64'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid_s  = 4'($urandom_range(0, 15));
      out_ready_s = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data_s[i*DW +: DW] = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
